// File: rtl/ddr2_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ddr2_ctrl_pkg
// Shared definitions for the DDR2 controller slice: basic ulogic vector
// types, DRAM command encodings on {cs_n, ras_n, cas_n, we_n}, the controller
// FSM state enum, host address field layout and counter sizing helpers.
// ---------------------------------------------------------------------------
package ddr2_ctrl_pkg;

  // Basic unsigned logic vector types used across the controller.
  typedef logic [1:0]  ulogic2_t;
  typedef logic [12:0] ulogic13_t;
  typedef logic [15:0] ulogic16_t;
  typedef logic [24:0] ulogic25_t;

  // Host address layout: {bank, row, col}.
  localparam int ADDR_W   = 25;
  localparam int DATA_W   = 16;
  localparam int BANK_W   = 2;
  localparam int ROW_W    = 13;
  localparam int COL_W    = 10;
  localparam int BANK_LSB = 23;
  localparam int ROW_LSB  = 10;
  localparam int COL_LSB  = 0;

  // Cycles the read wait continues after the dq capture cycle, before PRE.
  localparam int RD_TAIL  = 3;

  // DRAM command encodings on {cs_n, ras_n, cas_n, we_n}.
  typedef enum logic [3:0] {
    CMD_PRE = 4'b0010,
    CMD_ACT = 4'b0011,
    CMD_WR  = 4'b0100,
    CMD_RD  = 4'b0101,
    CMD_NOP = 4'b0111
  } ddr2_cmd_e;

  typedef enum logic [3:0] {
    ST_INIT,
    ST_IDLE,
    ST_ACT,
    ST_RCD,
    ST_WR,
    ST_WDAT,
    ST_RD,
    ST_RWAIT,
    ST_PRE,
    ST_RP
  } ddr2_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to hold values 0..max_val (at least one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/ddr2_ctrl_timer.sv
// ---------------------------------------------------------------------------
// ddr2_ctrl_timer
// Loadable down-counter shared by all controller waits. A load has priority;
// otherwise the count decrements once per cycle and sticks at zero.
// Ports:
//   ck, reset_n   clock / asynchronous active-low reset (count -> 0)
//   load_i        load load_val_i this cycle
//   load_val_i    value to load
//   count_o       current count
//   done_o        count is zero
// ---------------------------------------------------------------------------
module ddr2_ctrl_timer #(
  parameter int W = 4
) (
  input  logic         ck,
  input  logic         reset_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] count_o,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge ck or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;
  assign done_o  = (cnt_q == '0);

endmodule

// File: rtl/ddr2_ctrl.sv
// ---------------------------------------------------------------------------
// ddr2_ctrl
// Minimal close-page DDR2 controller: one host access at a time, each one is
// ACT -> tRCD -> RD/WR -> data phase -> PRE -> tRP -> IDLE.
// Ports:
//   ck, reset_n              clock (rising edge) / async active-low reset
//   req_valid/req_ready      host handshake, ready only in IDLE
//   req_write/addr/wdata     access type, {bank,row,col}, write word
//   rd_valid/rd_data         one-cycle pulse with first beat of read burst
//   cke, cs_n..we_n, ba,addr DRAM control / address pins
//   dq_out/dq_oe/dq_in       split data bus (tristate resolved above)
//   dqs_out/dqs_oe           write strobe and its enable
// Constraints: T_INIT >= 2, T_RCD >= 1, T_RP >= 1.
// ---------------------------------------------------------------------------
module ddr2_ctrl
  import ddr2_ctrl_pkg::*;
#(
  parameter int T_INIT = 4,
  parameter int T_RCD  = 2,
  parameter int T_RP   = 2,
  parameter int CL     = 7
) (
  input  logic        ck,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [24:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rd_valid,
  output logic [15:0] rd_data,
  output logic        cke,
  output logic        cs_n,
  output logic        ras_n,
  output logic        cas_n,
  output logic        we_n,
  output logic [1:0]  ba,
  output logic [12:0] addr,
  output logic [15:0] dq_out,
  output logic        dq_oe,
  input  logic [15:0] dq_in,
  output logic [1:0]  dqs_out,
  output logic        dqs_oe
);

  localparam int CNT_MAX = max_int(max_int(T_INIT, T_RCD), max_int(T_RP, CL + RD_TAIL));
  localparam int CNT_W   = cnt_width(CNT_MAX);

  // The INIT wait is armed in the first cycle after reset, which itself
  // counts as a cke-low cycle, hence the -2.
  localparam logic [CNT_W-1:0] INIT_LOAD  = CNT_W'(T_INIT - 2);
  // ACT is the first tRCD cycle.
  localparam logic [CNT_W-1:0] RCD_LOAD   = CNT_W'(T_RCD - 1);
  localparam logic [CNT_W-1:0] RP_LOAD    = CNT_W'(T_RP - 1);
  // Two strobe cycles after WR: count 1 -> dqs 00, count 0 -> dqs 11.
  localparam logic [CNT_W-1:0] WDAT_LOAD  = CNT_W'(1);
  // RWAIT starts at RD+1 with CL+RD_TAIL, so the count equals RD_TAIL in
  // cycle RD+CL+1 (capture) and reaches zero in RD+CL+4 (PRE follows).
  localparam logic [CNT_W-1:0] RWAIT_LOAD = CNT_W'(CL + RD_TAIL);
  localparam logic [CNT_W-1:0] CAP_CNT    = CNT_W'(RD_TAIL);

  ddr2_state_e state_q, state_d;
  logic        cke_q, cke_d;
  logic        init_run_q, init_run_d;
  logic [BANK_W-1:0] bank_q, bank_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic        write_q, write_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] dq_cap_q;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic [CNT_W-1:0] tmr_cnt;
  logic             tmr_done;
  logic             capture;
  ddr2_cmd_e        cmd;

  ddr2_ctrl_timer #(.W(CNT_W)) u_timer (
    .ck         (ck),
    .reset_n    (reset_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .count_o    (tmr_cnt),
    .done_o     (tmr_done)
  );

  // High for the whole read-capture cycle (RD+CL+1).
  assign capture = (state_q == ST_RWAIT) && (tmr_cnt == CAP_CNT);

  always_comb begin
    state_d    = state_q;
    cke_d      = cke_q;
    init_run_d = init_run_q;
    bank_d     = bank_q;
    row_d      = row_q;
    col_d      = col_q;
    write_d    = write_q;
    wdata_d    = wdata_q;
    rd_valid_d = capture;
    rd_data_d  = capture ? dq_cap_q : rd_data_q;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    cmd        = CMD_NOP;
    req_ready  = 1'b0;
    ba         = '0;
    addr       = '0;
    dq_out     = '0;
    dq_oe      = 1'b0;
    dqs_out    = 2'b00;
    dqs_oe     = 1'b0;

    case (state_q)
      ST_INIT: begin
        if (!cke_q) begin
          if (!init_run_q) begin
            tmr_load   = 1'b1;
            tmr_val    = INIT_LOAD;
            init_run_d = 1'b1;
          end else if (tmr_done) begin
            cke_d = 1'b1;
          end
        end else begin
          // One NOP cycle with cke high before accepting requests.
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          bank_d   = req_addr[BANK_LSB +: BANK_W];
          row_d    = req_addr[ROW_LSB +: ROW_W];
          col_d    = req_addr[COL_LSB +: COL_W];
          write_d  = req_write;
          wdata_d  = req_wdata;
          tmr_load = 1'b1;
          tmr_val  = RCD_LOAD;
          state_d  = ST_ACT;
        end
      end
      ST_ACT: begin
        cmd  = CMD_ACT;
        ba   = bank_q;
        addr = row_q;
        if (tmr_done) begin
          state_d = write_q ? ST_WR : ST_RD;
        end else begin
          state_d = ST_RCD;
        end
      end
      ST_RCD: begin
        ba = bank_q;
        if (tmr_done) begin
          state_d = write_q ? ST_WR : ST_RD;
        end
      end
      ST_WR: begin
        cmd      = CMD_WR;
        ba       = bank_q;
        addr     = {{(ROW_W - COL_W){1'b0}}, col_q};
        tmr_load = 1'b1;
        tmr_val  = WDAT_LOAD;
        state_d  = ST_WDAT;
      end
      ST_WDAT: begin
        ba      = bank_q;
        dq_oe   = 1'b1;
        dqs_oe  = 1'b1;
        dq_out  = wdata_q;
        dqs_out = tmr_done ? 2'b11 : 2'b00;
        if (tmr_done) begin
          state_d = ST_PRE;
        end
      end
      ST_RD: begin
        cmd      = CMD_RD;
        ba       = bank_q;
        addr     = {{(ROW_W - COL_W){1'b0}}, col_q};
        tmr_load = 1'b1;
        tmr_val  = RWAIT_LOAD;
        state_d  = ST_RWAIT;
      end
      ST_RWAIT: begin
        ba = bank_q;
        if (tmr_done) begin
          state_d = ST_PRE;
        end
      end
      ST_PRE: begin
        cmd      = CMD_PRE;
        ba       = bank_q;
        tmr_load = 1'b1;
        tmr_val  = RP_LOAD;
        state_d  = ST_RP;
      end
      ST_RP: begin
        ba = bank_q;
        if (tmr_done) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge ck or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_INIT;
      cke_q      <= 1'b0;
      init_run_q <= 1'b0;
      bank_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cke_q      <= cke_d;
      init_run_q <= init_run_d;
      bank_q     <= bank_d;
      row_q      <= row_d;
      col_q      <= col_d;
      write_q    <= write_d;
      wdata_q    <= wdata_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // The first read beat is taken on the falling edge, mid-cycle, and handed
  // to rd_data on the following rising edge.
  always_ff @(negedge ck or negedge reset_n) begin
    if (!reset_n) begin
      dq_cap_q <= '0;
    end else if (capture) begin
      dq_cap_q <= dq_in;
    end
  end

  assign {cs_n, ras_n, cas_n, we_n} = cmd;
  assign cke      = cke_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_ddr2_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ddr2_ctrl
// Directed sequence with randomized addresses/data for ddr2_ctrl. The bench
// plays the DRAM (stores written words, returns them CL+1 cycles after RD)
// and keeps its own host-level memory of what each address should hold.
// ---------------------------------------------------------------------------
module tb_ddr2_ctrl;

  localparam int T_INIT = 4;
  localparam int T_RCD  = 2;
  localparam int T_RP   = 2;
  localparam int CL     = 7;

  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_NOP = 4'b0111;

  logic        ck;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [24:0] req_addr;
  logic [15:0] req_wdata;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic        cke, cs_n, ras_n, cas_n, we_n;
  logic [1:0]  ba;
  logic [12:0] addr;
  logic [15:0] dq_out;
  logic        dq_oe;
  logic [15:0] dq_in;
  logic [1:0]  dqs_out;
  logic        dqs_oe;

  ddr2_ctrl #(.T_INIT(T_INIT), .T_RCD(T_RCD), .T_RP(T_RP), .CL(CL)) dut (
    .ck        (ck),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .cke       (cke),
    .cs_n      (cs_n),
    .ras_n     (ras_n),
    .cas_n     (cas_n),
    .we_n      (we_n),
    .ba        (ba),
    .addr      (addr),
    .dq_out    (dq_out),
    .dq_oe     (dq_oe),
    .dq_in     (dq_in),
    .dqs_out   (dqs_out),
    .dqs_oe    (dqs_oe)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // DRAM model state (pin level) and host-level reference memory.
  logic [15:0] dram    [int];
  logic [15:0] ref_mem [int];
  logic [1:0]  dram_bank = '0;
  logic [12:0] dram_row  = '0;
  int          wr_cyc     = -100;
  int          wr_key     = 0;
  int          rd_drv_cyc = -100;
  logic [15:0] rd_drv_val = '0;

  function automatic int key(input logic [1:0] b, input logic [12:0] r, input logic [9:0] c);
    return int'({b, r, c});
  endfunction

  function automatic logic [3:0] cmd_now();
    return {cs_n, ras_n, cas_n, we_n};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    int k;
    @(posedge ck);
    #1;
    cyc++;
    case (cmd_now())
      C_ACT: begin
        dram_bank = ba;
        dram_row  = addr;
      end
      C_WR: begin
        wr_cyc = cyc;
        wr_key = key(dram_bank, dram_row, addr[9:0]);
      end
      C_RD: begin
        k          = key(dram_bank, dram_row, addr[9:0]);
        rd_drv_cyc = cyc + CL + 1;
        rd_drv_val = dram.exists(k) ? dram[k] : 16'h0000;
      end
      default: ;
    endcase
    if (cyc == wr_cyc + 1 && dq_oe) dram[wr_key] = dq_out;
    // Valid data only in the capture cycle; noise everywhere else.
    dq_in = (cyc == rd_drv_cyc) ? rd_drv_val : 16'($urandom);
  endtask

  task automatic chk_reset_outputs(input string p);
    chk({p, " cke"}, cke, 0);
    chk({p, " cmd"}, cmd_now(), C_NOP);
    chk({p, " ba"}, ba, 0);
    chk({p, " addr"}, addr, 0);
    chk({p, " dq_oe"}, dq_oe, 0);
    chk({p, " dqs_oe"}, dqs_oe, 0);
    chk({p, " dq_out"}, dq_out, 0);
    chk({p, " dqs_out"}, dqs_out, 0);
    chk({p, " req_ready"}, req_ready, 0);
    chk({p, " rd_valid"}, rd_valid, 0);
    chk({p, " rd_data"}, rd_data, 0);
  endtask

  // Release reset mid-cycle; that cycle is cycle 1 of the init sequence.
  task automatic release_and_check_init(input string p);
    reset_n = 1'b1;
    #1;
    for (int c = 1; c <= T_INIT + 2; c++) begin
      if (c > 1) tick();
      chk($sformatf("%s init c%0d cke", p, c), cke, (c > T_INIT));
      chk($sformatf("%s init c%0d ready", p, c), req_ready, (c == T_INIT + 2));
      chk($sformatf("%s init c%0d cmd", p, c), cmd_now(), C_NOP);
    end
  endtask

  task automatic do_access(input logic wr, input logic [1:0] b, input logic [12:0] r,
                           input logic [9:0] c, input logic [15:0] d);
    logic [3:0]  cmd_l  [64];
    logic [1:0]  ba_l   [64];
    logic [12:0] addr_l [64];
    logic        oe_l   [64];
    logic        dqsoe_l[64];
    logic [1:0]  dqs_l  [64];
    logic [15:0] dq_l   [64];
    logic [15:0] rd_l   [64];
    int ready_rel, ncmd, nrv, rv_rel, k, cas, pre, ki;
    logic oe_any;
    logic [15:0] exp_rd, rd_before;
    string tg;
    tg = $sformatf("%s b%0d r%03h c%03h", wr ? "WR" : "RD", b, r, c);
    ready_rel = -1; ncmd = 0; nrv = 0; rv_rel = -1; oe_any = 1'b0;
    k = 0;
    while (!req_ready && k < 60) begin
      tick();
      k++;
    end
    chk({tg, " ready"}, req_ready, 1);
    if (!req_ready) return;
    rd_before = rd_data;
    ki = key(b, r, c);
    exp_rd = ref_mem.exists(ki) ? ref_mem[ki] : 16'h0000;
    if (wr) ref_mem[ki] = d;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = {b, r, c};
    req_wdata = d;
    for (int rel = 1; rel < 64; rel++) begin
      tick();
      if (rel == 1) begin
        // Keep req_valid asserted with junk while busy: must be ignored.
        req_write = 1'($urandom);
        req_addr  = 25'($urandom);
        req_wdata = 16'($urandom);
      end
      cmd_l[rel] = cmd_now(); ba_l[rel] = ba; addr_l[rel] = addr;
      oe_l[rel] = dq_oe; dqsoe_l[rel] = dqs_oe; dqs_l[rel] = dqs_out;
      dq_l[rel] = dq_out; rd_l[rel] = rd_data;
      oe_any = oe_any | dq_oe | dqs_oe;
      if (cmd_now() != C_NOP) ncmd++;
      if (rd_valid) begin
        nrv++;
        if (rv_rel < 0) rv_rel = rel;
      end
      if (req_ready) begin
        ready_rel = rel;
        break;
      end
    end
    req_valid = 1'b0;
    cas = 1 + T_RCD;
    pre = wr ? cas + 3 : cas + CL + 5;
    chk({tg, " act cmd"}, cmd_l[1], C_ACT);
    chk({tg, " act ba"}, ba_l[1], b);
    chk({tg, " act row"}, addr_l[1], r);
    chk({tg, " cas cmd"}, cmd_l[cas], wr ? C_WR : C_RD);
    chk({tg, " cas ba"}, ba_l[cas], b);
    chk({tg, " cas col"}, addr_l[cas], {3'b000, c});
    chk({tg, " pre cmd"}, cmd_l[pre], C_PRE);
    chk({tg, " cmd count"}, ncmd, 3);
    chk({tg, " ready again"}, ready_rel, pre + T_RP + 1);
    if (wr) begin
      chk({tg, " w+1 oe"}, {oe_l[cas+1], dqsoe_l[cas+1]}, 2'b11);
      chk({tg, " w+1 dqs"}, dqs_l[cas+1], 2'b00);
      chk({tg, " w+1 dq"}, dq_l[cas+1], d);
      chk({tg, " w+2 oe"}, {oe_l[cas+2], dqsoe_l[cas+2]}, 2'b11);
      chk({tg, " w+2 dqs"}, dqs_l[cas+2], 2'b11);
      chk({tg, " w+2 dq"}, dq_l[cas+2], d);
      chk({tg, " w+3 oe"}, {oe_l[cas+3], dqsoe_l[cas+3]}, 2'b00);
      chk({tg, " no rd_valid"}, nrv, 0);
      chk({tg, " rd_data held"}, rd_data, rd_before);
    end else begin
      chk({tg, " rd_valid pulses"}, nrv, 1);
      chk({tg, " rd_valid cycle"}, rv_rel, cas + CL + 2);
      chk({tg, " rd_data"}, rd_l[cas+CL+2], exp_rd);
      chk({tg, " no oe in read"}, oe_any, 0);
      chk({tg, " rd_data holds"}, rd_data, exp_rd);
    end
    $display("access %s done at cycle %0d", tg, cyc);
  endtask

  initial begin
    logic [1:0]  ob   [3];
    logic [12:0] orow [3];
    logic [9:0]  ocol [3];
    logic [15:0] od   [3];
    int pre_c [3];
    int idx, nact, npre, nwr, k;
    logic acc, rv_seen, found;
    logic [1:0]  rb;
    logic [12:0] rr;
    logic [15:0] rdat;

    reset_n   = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    dq_in     = '0;
    #2 reset_n = 1'b0;
    repeat (3) tick();
    chk_reset_outputs("por");
    release_and_check_init("por");

    // Reference write / read.
    do_access(1'b1, 2'd1, 13'h0123, 10'h005, 16'hBEEF);
    do_access(1'b0, 2'd1, 13'h0123, 10'h005, 16'h0000);

    // Highest column.
    rr = 13'($urandom); rdat = 16'($urandom);
    do_access(1'b1, 2'd2, rr, 10'h3FF, rdat);
    do_access(1'b0, 2'd2, rr, 10'h3FF, 16'h0000);

    // Three writes with req_valid held high throughout.
    k = 0;
    while (!req_ready && k < 60) begin
      tick();
      k++;
    end
    for (int i = 0; i < 3; i++) begin
      ob[i] = 2'($urandom); orow[i] = 13'($urandom);
      ocol[i] = 10'($urandom); od[i] = 16'($urandom);
      pre_c[i] = 0;
    end
    req_valid = 1'b1; req_write = 1'b1;
    req_addr = {ob[0], orow[0], ocol[0]}; req_wdata = od[0];
    idx = 0; nact = 0; npre = 0; nwr = 0;
    for (int t = 0; t < 200 && npre < 3; t++) begin
      acc = req_valid && req_ready;
      tick();
      if (acc) begin
        ref_mem[key(ob[idx], orow[idx], ocol[idx])] = od[idx];
        idx++;
        if (idx < 3) begin
          req_addr = {ob[idx], orow[idx], ocol[idx]}; req_wdata = od[idx];
        end else begin
          req_valid = 1'b0;
        end
      end
      case (cmd_now())
        C_ACT: begin
          if (nact < 3) begin
            chk($sformatf("b2b act%0d ba", nact), ba, ob[nact]);
            chk($sformatf("b2b act%0d row", nact), addr, orow[nact]);
            chk($sformatf("b2b act%0d after prev pre", nact), npre, nact);
            if (nact > 0) chk($sformatf("b2b act%0d pre gap", nact), cyc - pre_c[nact-1], T_RP + 2);
          end
          nact++;
        end
        C_PRE: begin
          if (npre < 3) pre_c[npre] = cyc;
          npre++;
        end
        C_WR: nwr++;
        default: ;
      endcase
    end
    req_valid = 1'b0;
    chk("b2b accepted", idx, 3);
    chk("b2b act count", nact, 3);
    chk("b2b wr count", nwr, 3);
    chk("b2b pre count", npre, 3);
    $display("back-to-back writes done at cycle %0d", cyc);
    for (int i = 0; i < 3; i++) do_access(1'b0, ob[i], orow[i], ocol[i], 16'h0000);

    // Random write/read pairs.
    for (int i = 0; i < 4; i++) begin
      rb = 2'($urandom); rr = 13'($urandom); rdat = 16'($urandom);
      k = int'($urandom_range(0, 1023));
      do_access(1'b1, rb, rr, 10'(k), rdat);
      do_access(1'b0, rb, rr, 10'(k), 16'h0000);
    end

    // Reset three cycles after RD.
    k = 0;
    while (!req_ready && k < 60) begin
      tick();
      k++;
    end
    req_valid = 1'b1; req_write = 1'b0;
    req_addr = {2'd1, 13'h0123, 10'h005};
    tick();
    req_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (cmd_now() == C_RD) found = 1'b1;
    end
    chk("midrd rd seen", found, 1);
    repeat (3) tick();
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("midrd");
    rv_seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      rv_seen = rv_seen | rd_valid | cke;
    end
    chk("midrd quiet in reset", rv_seen, 0);
    $display("mid-read reset applied at cycle %0d", cyc);
    release_and_check_init("rerun");
    do_access(1'b0, 2'd1, 13'h0123, 10'h005, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
